mips_mc_control: RTL and testbench
==================================

// Module: mips_mc_control
// PURPOSE
//  Multi-cycle control unit for the MIPS datapath; drives reg_dst, reg_wr, alu_op, mem_wr,
//  mem_rd, alusrc, mem2reg, branch, jr, jump, plus the multi-cycle strobes ir_wr, pc_wr, iord.
//  Decodes opcode/funct with a Moore FSM and stalls on a shared memory ready handshake.
//  Counts retired instructions and flags illegal encodings.
// PARAMETERS
//  CNT_W      32   width of retired-instruction counter
// PORTS
//  clk           in   1      rising-edge clock
//  rst           in   1      asynchronous, active-high reset
//  opcode        in   6      instr[31:26], valid from DECODE onward (IR held by ir_wr)
//  funct         in   6      instr[5:0]
//  zero          in   1      ALU zero flag
//  mem_ready     in   1      memory ack for current mem_rd/mem_wr request
//  reg_dst       out  1      1: write reg = rd, 0: rt
//  reg_wr        out  1      register file write enable
//  alu_op        out  3      ALU F: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
//  mem_wr        out  1      data memory write request
//  mem_rd        out  1      memory read request (fetch or load)
//  alusrc        out  1      1: B = sign-extended imm, 0: B = reg2
//  mem2reg       out  1      1: write-back data from memory, 0: from ALU
//  branch        out  1      beq in progress
//  jr            out  1      PC <= reg1_val
//  jump          out  1      PC <= {pc[31:28], instr[25:0], 2'b00}
//  ir_wr         out  1      latch fetched instruction
//  pc_wr         out  1      unconditional PC update (pc+4, jump, jr)
//  pc_en         out  1      pc_wr | (branch & zero)
//  iord          out  1      memory address: 0 PC, 1 ALU result
//  illegal       out  1      one-cycle pulse on unsupported opcode/funct
//  retired       out  CNT_W  retired instruction count
// BEHAVIOUR
//  Reset: state=FETCH, retired=0, all outputs 0 while rst high; first FETCH cycle after release.
//  Supported: R-type (op 0x00): add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, jr 0x08;
//   lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02. Any other op/funct is illegal.
//  Outputs are decoded from state only; pc_en is additionally AND-ed with zero (branch).
//  States and asserted outputs (unlisted = 0):
//   FETCH    mem_rd, iord=0; on mem_ready: ir_wr, pc_wr, alu_op=ADD -> DECODE; else hold.
//   DECODE   none; lw/sw->MEMADR, R-ALU->RTYPE_EX, jr->JR, beq->BEQ, addi->ADDI_EX,
//            j->JUMP, illegal->ILLEGAL.
//   MEMADR   alusrc, alu_op=ADD; -> MEMRD (lw) / MEMWR (sw).
//   MEMRD    mem_rd, iord, alusrc, alu_op=ADD; hold until mem_ready -> MEMWB.
//   MEMWB    reg_wr, mem2reg, reg_dst=0; retire -> FETCH.
//   MEMWR    mem_wr, iord, alusrc, alu_op=ADD; hold until mem_ready; retire -> FETCH.
//   RTYPE_EX alu_op from funct; -> RTYPE_WB.   RTYPE_WB reg_wr, reg_dst=1, same alu_op; retire.
//   ADDI_EX  alusrc, alu_op=ADD -> ADDI_WB.    ADDI_WB reg_wr, alusrc, reg_dst=0, ADD; retire.
//   BEQ      branch, alu_op=SUB; pc_en=zero; retire (taken or not) -> FETCH.
//   JUMP     jump, pc_wr; retire.   JR  jr, pc_wr; retire.
//   ILLEGAL  illegal=1 for one cycle, no retire, no writes -> FETCH.
//  Latency (mem_ready immediate): lw 5, sw/R/addi 4, beq/j/jr 3 cycles; each mem_ready-low
//   cycle in FETCH/MEMRD/MEMWR adds one cycle with request held stable.
//  Request stability: mem_rd/mem_wr/iord must not drop or change while waiting for mem_ready.
//  mem_ready outside FETCH/MEMRD/MEMWR is ignored.
//  retired increments once in the last state of each legal instruction; wraps at 2^CNT_W-1 -> 0.
//  rst asserted mid-instruction: immediate return to FETCH, partial results discarded,
//   no reg_wr/mem_wr on the reset edge or after it, retired cleared.
//  rd = 0 writes are not suppressed here; the register file ignores r0.
// STRUCTURE
//  Package mips_pkg: opcode/funct localparams, ALU_AND/OR/ADD/SUB/SLT codes, state enum.
//  Sub-module mips_alu_decode (combinational funct -> alu_op, legal flag), shared with
//   the single-cycle control.
// TESTING
//  lw, mem_ready=1: FETCH,DECODE,MEMADR,MEMRD,MEMWB; reg_wr&mem2reg in cycle 5; retired 0->1.
//  sw with mem_ready low 3 cycles in MEMWR -> mem_wr,iord held 4 cycles, then FETCH; no reg_wr.
//  beq zero=1 -> pc_en=1 in BEQ; zero=0 -> pc_en=0; both retire, 3 cycles each.
//  op=0x3F -> illegal pulse 1 cycle, retired unchanged, no writes, next FETCH.
//  rst pulsed during MEMRD -> outputs 0, state FETCH, retired=0, no reg_wr seen.
//  CNT_W=4: 16 addi -> retired wraps 15->0; funct 0x22 in RTYPE_WB gives alu_op=110.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS control units: opcodes, functs, ALU codes, FSM states.
package mips_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALU_W   = 3;
  localparam int unsigned ST_W    = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;

  localparam logic [FUNCT_W-1:0] F_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] F_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] F_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] F_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] F_SLT = 6'h2A;
  localparam logic [FUNCT_W-1:0] F_JR  = 6'h08;

  localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

  localparam logic [ST_W-1:0] ST_FETCH    = 4'd0;
  localparam logic [ST_W-1:0] ST_DECODE   = 4'd1;
  localparam logic [ST_W-1:0] ST_MEMADR   = 4'd2;
  localparam logic [ST_W-1:0] ST_MEMRD    = 4'd3;
  localparam logic [ST_W-1:0] ST_MEMWB    = 4'd4;
  localparam logic [ST_W-1:0] ST_MEMWR    = 4'd5;
  localparam logic [ST_W-1:0] ST_RTYPE_EX = 4'd6;
  localparam logic [ST_W-1:0] ST_RTYPE_WB = 4'd7;
  localparam logic [ST_W-1:0] ST_ADDI_EX  = 4'd8;
  localparam logic [ST_W-1:0] ST_ADDI_WB  = 4'd9;
  localparam logic [ST_W-1:0] ST_BEQ      = 4'd10;
  localparam logic [ST_W-1:0] ST_JUMP     = 4'd11;
  localparam logic [ST_W-1:0] ST_JR       = 4'd12;
  localparam logic [ST_W-1:0] ST_ILLEGAL  = 4'd13;

endpackage

// File: rtl/mips_alu_decode.sv
// R-type funct -> ALU function; legal is low for functs that are not ALU operations.
module mips_alu_decode
  import mips_pkg::*;
(
  input  logic [FUNCT_W-1:0] funct,
  output logic [ALU_W-1:0]   alu_op,
  output logic               legal
);

  // Pure lookup; unknown functs fall back to ADD with legal cleared.
  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b1;
    case (funct)
      F_ADD:   alu_op = ALU_ADD;
      F_SUB:   alu_op = ALU_SUB;
      F_AND:   alu_op = ALU_AND;
      F_OR:    alu_op = ALU_OR;
      F_SLT:   alu_op = ALU_SLT;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control: Moore FSM with memory-ready stalls, retire counter, illegal flag.
module mips_mc_control
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    opcode,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               reg_dst,
  output logic               reg_wr,
  output logic [ALU_W-1:0]   alu_op,
  output logic               mem_wr,
  output logic               mem_rd,
  output logic               alusrc,
  output logic               mem2reg,
  output logic               branch,
  output logic               jr,
  output logic               jump,
  output logic               ir_wr,
  output logic               pc_wr,
  output logic               pc_en,
  output logic               iord,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired
);

  logic [ST_W-1:0]  state;
  logic [ST_W-1:0]  state_next;
  logic [ALU_W-1:0] funct_alu_op;
  logic             funct_legal;
  logic             is_jr;
  logic             retire_c;

  mips_alu_decode u_alu_decode (
    .funct  (funct),
    .alu_op (funct_alu_op),
    .legal  (funct_legal)
  );

  assign is_jr = (opcode == OP_RTYPE) && (funct == F_JR);

  // State register; reset returns to FETCH immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_next;
  end

  // Next-state and state-decoded outputs; everything is forced low while rst is high.
  always_comb begin
    state_next = state;
    reg_dst    = 1'b0;
    reg_wr     = 1'b0;
    alu_op     = ALU_AND;
    mem_wr     = 1'b0;
    mem_rd     = 1'b0;
    alusrc     = 1'b0;
    mem2reg    = 1'b0;
    branch     = 1'b0;
    jr         = 1'b0;
    jump       = 1'b0;
    ir_wr      = 1'b0;
    pc_wr      = 1'b0;
    iord       = 1'b0;
    illegal    = 1'b0;
    retire_c   = 1'b0;
    pc_en      = 1'b0;

    case (state)
      ST_FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_wr      = 1'b1;
          pc_wr      = 1'b1;
          alu_op     = ALU_ADD;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = ST_MEMADR;
          OP_RTYPE: begin
            if (is_jr)            state_next = ST_JR;
            else if (funct_legal) state_next = ST_RTYPE_EX;
            else                  state_next = ST_ILLEGAL;
          end
          OP_BEQ:  state_next = ST_BEQ;
          OP_ADDI: state_next = ST_ADDI_EX;
          OP_J:    state_next = ST_JUMP;
          default: state_next = ST_ILLEGAL;
        endcase
      end
      ST_MEMADR: begin
        alusrc     = 1'b1;
        alu_op     = ALU_ADD;
        state_next = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
      end
      ST_MEMRD: begin
        mem_rd = 1'b1;
        iord   = 1'b1;
        alusrc = 1'b1;
        alu_op = ALU_ADD;
        if (mem_ready) state_next = ST_MEMWB;
      end
      ST_MEMWB: begin
        reg_wr     = 1'b1;
        mem2reg    = 1'b1;
        retire_c   = 1'b1;
        state_next = ST_FETCH;
      end
      ST_MEMWR: begin
        mem_wr = 1'b1;
        iord   = 1'b1;
        alusrc = 1'b1;
        alu_op = ALU_ADD;
        if (mem_ready) begin
          retire_c   = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_RTYPE_EX: begin
        alu_op     = funct_alu_op;
        state_next = ST_RTYPE_WB;
      end
      ST_RTYPE_WB: begin
        reg_wr     = 1'b1;
        reg_dst    = 1'b1;
        alu_op     = funct_alu_op;
        retire_c   = 1'b1;
        state_next = ST_FETCH;
      end
      ST_ADDI_EX: begin
        alusrc     = 1'b1;
        alu_op     = ALU_ADD;
        state_next = ST_ADDI_WB;
      end
      ST_ADDI_WB: begin
        reg_wr     = 1'b1;
        alusrc     = 1'b1;
        alu_op     = ALU_ADD;
        retire_c   = 1'b1;
        state_next = ST_FETCH;
      end
      ST_BEQ: begin
        branch     = 1'b1;
        alu_op     = ALU_SUB;
        retire_c   = 1'b1;
        state_next = ST_FETCH;
      end
      ST_JUMP: begin
        jump       = 1'b1;
        pc_wr      = 1'b1;
        retire_c   = 1'b1;
        state_next = ST_FETCH;
      end
      ST_JR: begin
        jr         = 1'b1;
        pc_wr      = 1'b1;
        retire_c   = 1'b1;
        state_next = ST_FETCH;
      end
      ST_ILLEGAL: begin
        illegal    = 1'b1;
        state_next = ST_FETCH;
      end
      default: state_next = ST_FETCH;
    endcase

    if (rst) begin
      reg_dst  = 1'b0;
      reg_wr   = 1'b0;
      alu_op   = ALU_AND;
      mem_wr   = 1'b0;
      mem_rd   = 1'b0;
      alusrc   = 1'b0;
      mem2reg  = 1'b0;
      branch   = 1'b0;
      jr       = 1'b0;
      jump     = 1'b0;
      ir_wr    = 1'b0;
      pc_wr    = 1'b0;
      iord     = 1'b0;
      illegal  = 1'b0;
      retire_c = 1'b0;
    end

    pc_en = pc_wr | (branch & zero);
  end

  // Retired-instruction counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           retired <= '0;
    else if (retire_c) retired <= retired + CNT_W'(1);
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Randomized bench for mips_mc_control against an instruction-level behavioural model.
module tb_mips_mc_control;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic             mem_ready;
  logic             reg_dst, reg_wr, mem_wr, mem_rd, alusrc, mem2reg;
  logic             branch, jr, jump, ir_wr, pc_wr, pc_en, iord, illegal;
  logic [2:0]       alu_op;
  logic [CNT_W-1:0] retired;

  int checks = 0;
  int errors = 0;
  int exp_retired = 0;

  mips_mc_control #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .funct     (funct),
    .zero      (zero),
    .mem_ready (mem_ready),
    .reg_dst   (reg_dst),
    .reg_wr    (reg_wr),
    .alu_op    (alu_op),
    .mem_wr    (mem_wr),
    .mem_rd    (mem_rd),
    .alusrc    (alusrc),
    .mem2reg   (mem2reg),
    .branch    (branch),
    .jr        (jr),
    .jump      (jump),
    .ir_wr     (ir_wr),
    .pc_wr     (pc_wr),
    .pc_en     (pc_en),
    .iord      (iord),
    .illegal   (illegal),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Instruction-level model: one instruction, fs fetch-stall cycles, ms data-stall cycles.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fs, input int ms);
    bit is_lw, is_sw, is_r, is_jr, is_beq, is_addi, is_j, legal, mem_op;
    logic [2:0] r_alu;
    int lat, total, m;
    int n_rd, n_wr, n_iord, n_src, n_regwr, n_irwr, n_pcwr, n_pcen;
    int n_br, n_jmp, n_jr, n_ill, n_clash;
    logic wb_dst, wb_m2r, wb_src;
    logic [2:0] wb_alu;
    is_lw = (op == 6'h23);
    is_sw = (op == 6'h2B);
    is_beq = (op == 6'h04);
    is_addi = (op == 6'h08);
    is_j = (op == 6'h02);
    is_jr = (op == 6'h00) && (fn == 6'h08);
    is_r = 1'b0;
    r_alu = 3'b000;
    if (op == 6'h00) begin
      is_r = 1'b1;
      case (fn)
        6'h20: r_alu = 3'b010;
        6'h22: r_alu = 3'b110;
        6'h24: r_alu = 3'b000;
        6'h25: r_alu = 3'b001;
        6'h2A: r_alu = 3'b111;
        default: is_r = 1'b0;
      endcase
    end
    mem_op = is_lw || is_sw;
    legal = mem_op || is_r || is_jr || is_beq || is_addi || is_j;
    m = mem_op ? ms : 0;
    if (is_lw) lat = 5;
    else if (is_sw || is_r || is_addi) lat = 4;
    else lat = 3;
    total = lat + fs + m;
    {n_rd, n_wr, n_iord, n_src, n_regwr, n_irwr, n_pcwr} = '0;
    {n_pcen, n_br, n_jmp, n_jr, n_ill, n_clash} = '0;
    wb_dst = 1'b0; wb_m2r = 1'b0; wb_src = 1'b0; wb_alu = 3'b000;

    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      opcode = op; funct = fn; zero = z;
      if (c < fs) mem_ready = 1'b0;
      else if (c == fs) mem_ready = 1'b1;
      else if (mem_op && c >= fs + 3 && c < fs + 3 + m) mem_ready = 1'b0;
      else if (mem_op && c == fs + 3 + m) mem_ready = 1'b1;
      else mem_ready = 1'($urandom);
      #1;
      if (c == 0) begin
        chk("retired_at_fetch", 32'(retired), 32'(exp_retired));
        chk("fetch_mem_rd", 32'(mem_rd), 32'd1);
        chk("fetch_iord", 32'(iord), 32'd0);
      end
      n_rd += int'(mem_rd);   n_wr += int'(mem_wr);   n_iord += int'(iord);
      n_src += int'(alusrc);  n_regwr += int'(reg_wr); n_irwr += int'(ir_wr);
      n_pcwr += int'(pc_wr);  n_pcen += int'(pc_en);  n_br += int'(branch);
      n_jmp += int'(jump);    n_jr += int'(jr);       n_ill += int'(illegal);
      n_clash += int'(mem_rd && mem_wr);
      if (reg_wr) begin
        wb_dst = reg_dst; wb_m2r = mem2reg; wb_src = alusrc; wb_alu = alu_op;
      end
    end

    chk("mem_rd_cycles", 32'(n_rd), 32'(fs + 1 + (is_lw ? m + 1 : 0)));
    chk("mem_wr_cycles", 32'(n_wr), 32'(is_sw ? m + 1 : 0));
    chk("iord_cycles", 32'(n_iord), 32'(mem_op ? m + 1 : 0));
    chk("alusrc_cycles", 32'(n_src), 32'(mem_op ? m + 2 : (is_addi ? 2 : 0)));
    chk("reg_wr_cycles", 32'(n_regwr), 32'((is_lw || is_r || is_addi) ? 1 : 0));
    chk("ir_wr_cycles", 32'(n_irwr), 32'd1);
    chk("pc_wr_cycles", 32'(n_pcwr), 32'((is_j || is_jr) ? 2 : 1));
    chk("pc_en_cycles", 32'(n_pcen), 32'(((is_j || is_jr) ? 2 : 1) + ((is_beq && z) ? 1 : 0)));
    chk("branch_cycles", 32'(n_br), 32'(is_beq ? 1 : 0));
    chk("jump_cycles", 32'(n_jmp), 32'(is_j ? 1 : 0));
    chk("jr_cycles", 32'(n_jr), 32'(is_jr ? 1 : 0));
    chk("illegal_cycles", 32'(n_ill), 32'(legal ? 0 : 1));
    chk("rd_wr_clash", 32'(n_clash), 32'd0);
    if (is_lw || is_r || is_addi) begin
      chk("wb_reg_dst", 32'(wb_dst), 32'(is_r));
      chk("wb_mem2reg", 32'(wb_m2r), 32'(is_lw));
      chk("wb_alusrc", 32'(wb_src), 32'(is_addi));
      chk("wb_alu_op", 32'(wb_alu), 32'(is_r ? r_alu : (is_addi ? 3'b010 : 3'b000)));
    end
    if (legal) exp_retired = (exp_retired + 1) % (1 << CNT_W);
  endtask

  // One FETCH-stall cycle used to observe the counter between instructions.
  task automatic idle_check(input string tag);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk(tag, 32'(retired), 32'(exp_retired));
    chk("idle_mem_rd", 32'(mem_rd), 32'd1);
  endtask

  function automatic bit is_legal_op(input logic [5:0] op);
    return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 ||
           op == 6'h08 || op == 6'h02;
  endfunction

  function automatic bit is_legal_r(input logic [5:0] fn);
    return fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 ||
           fn == 6'h2A || fn == 6'h08;
  endfunction

  initial begin
    logic [5:0] op, fn;
    logic [5:0] r_functs [5];
    r_functs[0] = 6'h20; r_functs[1] = 6'h22; r_functs[2] = 6'h24;
    r_functs[3] = 6'h25; r_functs[4] = 6'h2A;

    rst = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_mem_rd", 32'(mem_rd), 32'd0);
    chk("reset_ir_wr", 32'(ir_wr), 32'd0);
    chk("reset_pc_en", 32'(pc_en), 32'd0);
    chk("reset_retired", 32'(retired), 32'd0);
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b0;

    run_instr(6'h23, 6'h00, 1'b0, 0, 0);
    run_instr(6'h2B, 6'h11, 1'b0, 0, 3);
    run_instr(6'h04, 6'h00, 1'b1, 0, 0);
    run_instr(6'h04, 6'h00, 1'b0, 0, 0);
    run_instr(6'h3F, 6'h00, 1'b0, 0, 0);
    run_instr(6'h00, 6'h22, 1'b0, 1, 0);
    run_instr(6'h00, 6'h08, 1'b1, 0, 0);
    run_instr(6'h02, 6'h00, 1'b0, 2, 0);
    run_instr(6'h00, 6'h3F, 1'b0, 0, 0);
    idle_check("retired_directed");

    for (int i = 0; i < 16; i++) run_instr(6'h08, 6'($urandom), 1'($urandom), 0, 0);
    idle_check("retired_after_wrap");

    // Reset in the middle of a stalled load: no write-back, counter cleared.
    begin
      int i;
      i = 0;
      while (i < 4) begin
        @(negedge clk);
        opcode = 6'h23; funct = 6'h00;
        mem_ready = (i == 0) ? 1'b1 : ((i == 3) ? 1'b0 : 1'($urandom));
        i++;
      end
      #1;
      chk("memrd_mem_rd", 32'(mem_rd), 32'd1);
      chk("memrd_iord", 32'(iord), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_mem_rd", 32'(mem_rd), 32'd0);
      chk("rst_iord", 32'(iord), 32'd0);
      chk("rst_reg_wr", 32'(reg_wr), 32'd0);
      chk("rst_retired", 32'(retired), 32'd0);
      mem_ready = 1'b1;
      @(negedge clk);
      chk("rst_hold_reg_wr", 32'(reg_wr), 32'd0);
      rst = 1'b0; mem_ready = 1'b0;
      #1;
      chk("post_rst_fetch", 32'(mem_rd), 32'd1);
      chk("post_rst_reg_wr", 32'(reg_wr), 32'd0);
      exp_retired = 0;
    end

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 8))
        0: begin op = 6'h23; fn = 6'($urandom); end
        1: begin op = 6'h2B; fn = 6'($urandom); end
        2: begin op = 6'h00; fn = r_functs[$urandom_range(0, 4)]; end
        3: begin op = 6'h00; fn = 6'h08; end
        4: begin op = 6'h04; fn = 6'($urandom); end
        5: begin op = 6'h08; fn = 6'($urandom); end
        6: begin op = 6'h02; fn = 6'($urandom); end
        7: begin
          op = 6'($urandom);
          while (is_legal_op(op)) op = 6'($urandom);
          fn = 6'($urandom);
        end
        default: begin
          op = 6'h00;
          fn = 6'($urandom);
          while (is_legal_r(fn)) fn = 6'($urandom);
        end
      endcase
      run_instr(op, fn, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 4));
    end
    idle_check("retired_final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
